// File: rtl/wb_csr_bank_param_if.sv
// Wishbone-style slave bus used by the CSR bank: request, address/data and the
// registered ack/err response plus the combinational block-select flag.
interface wb_csr_bank_param_if #(
    parameter int ADR_W  = 16,
    parameter int DATA_W = 8
);
    logic [ADR_W-1:0]  wb_adr_i;
    logic [ADR_W-1:0]  wb_base_adr_i;
    logic              wb_wen_i;
    logic              wb_stb_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic              wb_val_o;

    modport slave (
        input  wb_adr_i, wb_base_adr_i, wb_wen_i, wb_stb_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_val_o
    );

    modport master (
        output wb_adr_i, wb_base_adr_i, wb_wen_i, wb_stb_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_val_o
    );
endinterface

// File: rtl/wb_csr_bank_param.sv
// Parametrised control/status register bank with self-clearing pulse bits and a
// one-shot ack/err handshake. Define CSR_LOCK_EN to add a write-once LOCK register.
module wb_csr_bank_param #(
    parameter int ADR_W        = 16,
    parameter int DATA_W       = 8,
    parameter int BLK_ADR_BITS = 5,
    parameter int N_CTRL       = 4,
    parameter int N_STAT       = 2,
    parameter logic [N_CTRL*DATA_W-1:0] CTRL_RST   = '0,
    parameter logic [N_CTRL*DATA_W-1:0] PULSE_MASK = '0
) (
    input  logic                       clk40MHz_i,
    input  logic                       rst_i,
    wb_csr_bank_param_if.slave         wb,
    output logic [N_CTRL*DATA_W-1:0]   ctrl_o,
    output logic [N_CTRL-1:0]          ctrl_wr_o,
    input  logic [N_STAT*DATA_W-1:0]   stat_i
);

    generate
        if (N_CTRL + N_STAT + 1 > 2**BLK_ADR_BITS) begin : g_bad_cfg
            $error("wb_csr_bank_param: register map does not fit in BLK_ADR_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RESP, S_HOLD} state_t;

    state_t                    state_q, state_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic [DATA_W-1:0]         dat_q, dat_d;
    logic [N_CTRL*DATA_W-1:0]  ctrl_q, ctrl_d;
    logic [N_CTRL-1:0]         ctrl_wr_q, ctrl_wr_d;

    logic [31:0]               off_n;
    logic                      hit_ctrl, hit_stat, hit_lock, locked;
    logic [DATA_W-1:0]         rd_val;

    assign off_n = 32'(wb.wb_adr_i[BLK_ADR_BITS-1:0]);
    // XOR-and-shift compares only the block-select bits above the local offset.
    assign wb.wb_val_o = (((wb.wb_adr_i ^ wb.wb_base_adr_i) >> BLK_ADR_BITS) == '0);

`ifdef CSR_LOCK_EN
    logic lock_q, lock_d;
    assign hit_lock = (off_n == 32'(N_CTRL + N_STAT));
    assign locked   = lock_q;

    always_ff @(posedge clk40MHz_i or posedge rst_i) begin
        if (rst_i) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end
`else
    assign hit_lock = 1'b0;
    assign locked   = 1'b0;
`endif

    always_ff @(posedge clk40MHz_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            ctrl_q    <= CTRL_RST;
            ctrl_wr_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            ctrl_q    <= ctrl_d;
            ctrl_wr_q <= ctrl_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = dat_q;
        // Pulse bits fall back to 0 unless this cycle's write sets them again.
        ctrl_d    = ctrl_q & ~PULSE_MASK;
        ctrl_wr_d = '0;
        hit_ctrl  = 1'b0;
        hit_stat  = 1'b0;
        rd_val    = '0;
`ifdef CSR_LOCK_EN
        lock_d    = lock_q;
        if (hit_lock) rd_val = {{(DATA_W-1){1'b0}}, lock_q};
`endif
        for (int k = 0; k < N_CTRL; k++) begin
            if (off_n == 32'(k)) begin
                hit_ctrl = 1'b1;
                rd_val   = ctrl_q[k*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < N_STAT; j++) begin
            if (off_n == 32'(N_CTRL + j)) begin
                hit_stat = 1'b1;
                rd_val   = stat_i[j*DATA_W +: DATA_W];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (wb.wb_stb_i && wb.wb_val_o) begin
                    state_d = S_RESP;
                    if (wb.wb_wen_i) begin
                        if (hit_ctrl && !locked) begin
                            ack_d = 1'b1;
                            for (int k = 0; k < N_CTRL; k++) begin
                                if (off_n == 32'(k)) begin
                                    ctrl_d[k*DATA_W +: DATA_W] = wb.wb_dat_i;
                                    ctrl_wr_d[k]               = 1'b1;
                                end
                            end
                        end else if (hit_lock) begin
                            ack_d = 1'b1;
`ifdef CSR_LOCK_EN
                            lock_d = lock_q | wb.wb_dat_i[0];
`endif
                        end else begin
                            err_d = 1'b1;
                            dat_d = '0;
                        end
                    end else if (hit_ctrl || hit_stat || hit_lock) begin
                        ack_d = 1'b1;
                        dat_d = rd_val;
                    end else begin
                        err_d = 1'b1;
                        dat_d = '0;
                    end
                end
            end
            S_RESP:  state_d = S_HOLD;
            S_HOLD:  if (!wb.wb_stb_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign ctrl_o      = ctrl_q;
    assign ctrl_wr_o   = ctrl_wr_q;

endmodule

// File: tb/tb_wb_csr_bank_param.sv
// Directed bench for wb_csr_bank_param: reset, RW/RO access, pulse bits, error
// paths, foreign-block filtering and (with CSR_LOCK_EN) the lock register.
`timescale 1ns/1ps
module tb_wb_csr_bank_param;

    localparam logic [31:0] CTRL_RST_V   = 32'h1200_0000;
    localparam logic [31:0] PULSE_MASK_V = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl;
    logic [3:0]  ctrl_wr;
    logic [15:0] stat;

    int n_tests = 0;
    int n_fail  = 0;

    logic        r_ack, r_err, r_ack2;
    logic [7:0]  r_dat;
    logic [3:0]  r_wr, r_wr2;
    logic [31:0] r_ctrl, r_ctrl2;
    int          r_lat;
    int          cnt;

    wb_csr_bank_param_if #(.ADR_W(16), .DATA_W(8)) wb ();

    wb_csr_bank_param #(
        .ADR_W(16), .DATA_W(8), .BLK_ADR_BITS(5), .N_CTRL(4), .N_STAT(2),
        .CTRL_RST(CTRL_RST_V), .PULSE_MASK(PULSE_MASK_V)
    ) dut (
        .clk40MHz_i (clk),
        .rst_i      (rst),
        .wb         (wb),
        .ctrl_o     (ctrl),
        .ctrl_wr_o  (ctrl_wr),
        .stat_i     (stat)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus transfer; records the response cycle and the cycle after it.
    task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d);
        int cyc;
        @(posedge clk); #1;
        wb.wb_wen_i = w;
        wb.wb_adr_i = a;
        wb.wb_dat_i = d;
        wb.wb_stb_i = 1'b1;
        r_ack = 1'b0;
        r_err = 1'b0;
        cyc   = 0;
        while (!(r_ack || r_err) && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            r_ack = wb.wb_ack_o;
            r_err = wb.wb_err_o;
        end
        r_lat  = cyc;
        r_dat  = wb.wb_dat_o;
        r_wr   = ctrl_wr;
        r_ctrl = ctrl;
        wb.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        r_ack2  = wb.wb_ack_o | wb.wb_err_o;
        r_wr2   = ctrl_wr;
        r_ctrl2 = ctrl;
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        stat = 16'h0000;
        wb.wb_adr_i = 16'h0000;
        wb.wb_base_adr_i = 16'h0020;
        wb.wb_wen_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_dat_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",  {31'd0, wb.wb_ack_o}, 32'd0);
        check("rst_err",  {31'd0, wb.wb_err_o}, 32'd0);
        check("rst_dat",  {24'd0, wb.wb_dat_o}, 32'd0);
        check("rst_ctrl", ctrl, CTRL_RST_V);
        check("rst_wr",   {28'd0, ctrl_wr}, 32'd0);
        rst = 1'b0;

        // Reset asserted while the FSM is in RESP with a write just committed.
        @(posedge clk); #1;
        wb.wb_wen_i = 1'b1; wb.wb_adr_i = 16'h0022; wb.wb_dat_i = 8'h77; wb.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        check("t1_ack_before", {31'd0, wb.wb_ack_o}, 32'd1);
        check("t1_wr_before",  {28'd0, ctrl_wr}, 32'h4);
        #2 rst = 1'b1;
        #1;
        check("t1_ack_async",  {31'd0, wb.wb_ack_o}, 32'd0);
        check("t1_err_async",  {31'd0, wb.wb_err_o}, 32'd0);
        check("t1_wr_async",   {28'd0, ctrl_wr}, 32'd0);
        check("t1_ctrl_async", ctrl, CTRL_RST_V);
        wb.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        access(1'b0, 16'h0023, 8'h00);
        check("t1_next_ack", {31'd0, r_ack}, 32'd1);
        check("t1_next_dat", {24'd0, r_dat}, 32'h12);

        // Plain write / read-back / held strobe.
        access(1'b1, 16'h0020, 8'hA5);
        check("t2_ack",     {31'd0, r_ack}, 32'd1);
        check("t2_lat",     r_lat, 32'd1);
        check("t2_wr",      {28'd0, r_wr}, 32'h1);
        check("t2_wr_off",  {28'd0, r_wr2}, 32'h0);
        check("t2_ack_1cy", {31'd0, r_ack2}, 32'd0);
        check("t2_ctrl",    r_ctrl2, 32'h1200_00A5);
        access(1'b0, 16'h0020, 8'h00);
        check("t2_rd_ack",  {31'd0, r_ack}, 32'd1);
        check("t2_rd_dat",  {24'd0, r_dat}, 32'hA5);
        @(posedge clk); #1;
        wb.wb_wen_i = 1'b0; wb.wb_adr_i = 16'h0020; wb.wb_stb_i = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (wb.wb_ack_o) cnt++;
        end
        check("t2_one_ack", cnt, 32'd1);
        wb.wb_stb_i = 1'b0;
        repeat (2) @(posedge clk);

        // Pulse bit reg1[1]; reg1[0] is an ordinary bit.
        access(1'b1, 16'h0021, 8'h02);
        check("t3_pulse_hi", {24'd0, r_ctrl[15:8]}, 32'h02);
        check("t3_pulse_lo", {24'd0, r_ctrl2[15:8]}, 32'h00);
        access(1'b0, 16'h0021, 8'h00);
        check("t3_rd_dat",   {24'd0, r_dat}, 32'h00);
        access(1'b1, 16'h0021, 8'h03);
        check("t3_mix_hi",   {24'd0, r_ctrl[15:8]}, 32'h03);
        check("t3_mix_lo",   {24'd0, r_ctrl2[15:8]}, 32'h01);

        // Status reads and error paths.
        stat = 16'h3C7E;
        access(1'b0, 16'h0024, 8'h00);
        check("t4_stat0", {24'd0, r_dat}, 32'h7E);
        access(1'b0, 16'h0025, 8'h00);
        check("t4_stat1", {24'd0, r_dat}, 32'h3C);
        access(1'b1, 16'h0024, 8'h55);
        check("t4_wst_err",  {31'd0, r_err}, 32'd1);
        check("t4_wst_ack",  {31'd0, r_ack}, 32'd0);
        check("t4_wst_wr",   {28'd0, r_wr}, 32'd0);
        check("t4_wst_ctrl", r_ctrl2, 32'h1200_01A5);
        access(1'b0, 16'h003F, 8'h00);
        check("t4_unm_err",  {31'd0, r_err}, 32'd1);
        check("t4_unm_dat",  {24'd0, r_dat}, 32'h00);

        // Foreign block address.
        @(posedge clk); #1;
        wb.wb_adr_i = 16'h0020;
        #1 check("t5_val_own", {31'd0, wb.wb_val_o}, 32'd1);
        wb.wb_wen_i = 1'b0; wb.wb_adr_i = 16'h0040; wb.wb_stb_i = 1'b1;
        #1 check("t5_val_other", {31'd0, wb.wb_val_o}, 32'd0);
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (wb.wb_ack_o || wb.wb_err_o) cnt++;
        end
        check("t5_no_resp", cnt, 32'd0);
        wb.wb_stb_i = 1'b0;
        repeat (2) @(posedge clk);

`ifdef CSR_LOCK_EN
        access(1'b1, 16'h0026, 8'h01);
        check("t6_lock_ack", {31'd0, r_ack}, 32'd1);
        access(1'b0, 16'h0026, 8'h00);
        check("t6_lock_rd",  {24'd0, r_dat}, 32'h01);
        access(1'b1, 16'h0020, 8'hFF);
        check("t6_lkd_err",  {31'd0, r_err}, 32'd1);
        check("t6_lkd_wr",   {28'd0, r_wr}, 32'd0);
        check("t6_lkd_ctrl", {24'd0, r_ctrl2[7:0]}, 32'hA5);
        access(1'b1, 16'h0026, 8'h00);
        access(1'b1, 16'h0020, 8'hFF);
        check("t6_still_err", {31'd0, r_err}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        access(1'b1, 16'h0020, 8'hFF);
        check("t6_unlk_ack",  {31'd0, r_ack}, 32'd1);
        check("t6_unlk_ctrl", {24'd0, r_ctrl2[7:0]}, 32'hFF);
`else
        access(1'b0, 16'h0026, 8'h00);
        check("t6_nolock_err", {31'd0, r_err}, 32'd1);
        access(1'b1, 16'h0026, 8'h01);
        check("t6_nolock_werr", {31'd0, r_err}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
